// File: rtl/apb_pkg.sv
// Shared APB definitions for the master bridge, slave and interface.
// Holds the common bus widths and the master FSM state encoding.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts cycles while enabled and flags the last allowed one.
// Saturates instead of wrapping; TIMEOUT = 0 disables the expiry flag entirely.
module apb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of ACCESS cycles already completed, so the
  // current cycle is the TIMEOUT-th one when cnt_q reaches LAST.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (TIMEOUT > 0) && enable_i && (cnt_q == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// Requester end of the APB link: one command -> one SETUP/ACCESS transfer -> one response.
// Wait-state tolerant; a watchdog ends an ACCESS phase that never sees pready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);
  apb_mst_state_e    state_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              wd_expired;

  apb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .pclk      (pclk),
    .presetn   (presetn),
    .enable_i  (state_q == ACCESS),
    .clear_i   (state_q != ACCESS),
    .expired_o (wd_expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the watchdog when both land in the same cycle.
          if (pready) begin
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (wd_expired) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a behavioural APB slave and a response scoreboard.
module tb_apb_master_bridge;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Behavioural slave: n_wait wait states, optional hang and error injection.
  int          n_wait = 0;
  int          acc_cnt = 0;
  logic        hang = 1'b0;
  logic        err_mode = 1'b0;
  logic [31:0] mem [256] = '{default: 32'h0};

  assign pready  = !hang && (acc_cnt >= n_wait);
  assign pslverr = err_mode && psel && penable && pready;
  assign prdata  = mem[paddr[9:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr) mem[paddr[9:2]] <= pwdata;
  end

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: bound expired", tag);
  endtask

  // One full transfer: issue, follow the APB phases, hold the response dly cycles, consume.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int nw, input logic hg, input logic er, input int dly);
    exp_t e;
    int   lat, acc, exp_acc;
    n_wait   = nw;
    hang     = hg;
    err_mode = er;
    if (hg) begin
      e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
      exp_acc = TIMEOUT;
    end else begin
      e = '{rdata: wr ? 32'h0 : mem[addr[9:2]], err: er, tmo: 1'b0};
      exp_acc = nw + 1;
    end
    @(negedge pclk);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge pclk);
    exp_q.push_back(e);
    #1;
    cmd_valid = 1'b0;
    check("setup_psel", {31'b0, psel}, 32'd1);
    check("setup_penable", {31'b0, penable}, 32'd0);
    check("setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("setup_paddr", paddr, addr);
    lat = 0;
    acc = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge pclk); #1;
      lat++;
      if (psel && penable) begin
        acc++;
        check("access_paddr", paddr, addr);
        check("access_pwrite", {31'b0, pwrite}, {31'b0, wr});
        check("access_pwdata", pwdata, wr ? wdata : 32'h0);
      end
    end
    if (!rsp_valid) begin
      bound_fail("rsp_valid_wait");
      return;
    end
    check("access_cycles", acc, exp_acc);
    check("rsp_latency", lat, 1 + exp_acc);
    check("resp_psel_low", {30'b0, psel, penable}, 32'd0);
    repeat (dly) begin
      @(negedge pclk);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("hold_rdata", rsp_rdata, exp_q[0].rdata);
    end
    @(negedge pclk);
    rsp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      bound_fail("scoreboard_empty");
    end else begin
      e = exp_q.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.tmo});
    end
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    hang = 1'b0;
    err_mode = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1;
    check("rst_psel_penable", {30'b0, psel, penable}, 32'd0);
    check("rst_pwrite", {31'b0, pwrite}, 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;

    run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, 0);
    check("read_back_0x10", mem[4], 32'hDEADBEEF);
    run_cmd(1'b0, 32'h10, 32'hFFFF_FFFF, 3, 1'b0, 1'b0, 1);
    run_cmd(1'b1, 32'h30, 32'hCAFEF00D, 1, 1'b0, 1'b1, 0);
    run_cmd(1'b0, 32'h30, 32'h0, 0, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 0, 1'b1, 1'b0, 2);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d;
      a = {22'b0, 8'($urandom_range(8, 63)), 2'b00};
      d = $urandom;
      run_cmd(1'b1, a, d, $urandom_range(0, 2), 1'b0, 1'b0, $urandom_range(0, 2));
      run_cmd(1'b0, a, 32'h0, $urandom_range(0, 2), 1'b0, 1'b0, $urandom_range(0, 2));
    end

    // Held response then reset in the middle of the following ACCESS phase.
    run_cmd(1'b1, 32'h44, 32'h000055AA, 0, 1'b0, 1'b0, 5);
    hang = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("pre_reset_access", {30'b0, psel, penable}, 32'd3);
    presetn = 1'b0;
    #1;
    check("reset_psel_penable", {30'b0, psel, penable}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    hang = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    check("no_rsp_after_reset", {31'b0, rsp_valid}, 32'd0);
    run_cmd(1'b0, 32'h44, 32'h0, 0, 1'b0, 1'b0, 0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
